rdo_packet_buffer: RTL and testbench
====================================

// Module: rdo_packet_buffer
// PURPOSE
//  Packet-aware readout buffer directly downstream of the VA/ADC readout sequencer.
//  - Input: the sequencer's single-cycle write strobes, 16-bit words, clk_sys domain.
//  - Framing: validates the frame HEADER(0xAAAA), TRIG-INFO, {CH-INFO,DATA}*, TRAILER(0xBBBB), STATUS.
//  - Storage: writes words speculatively; commits only complete packets.
//  - Output: whole packets on a valid/ready stream for the host-link stage.
// PARAMETERS
//  ADDR_W     6   log2 of buffer depth (DEPTH = 2**ADDR_W words; one slot always kept empty)
//  MAX_WORDS  200 longest legal packet in words; a packet that reaches this length is aborted
// PORTS
//  clk_sys        in   1   system clock (50 MHz); the only clock
//  rstn           in   1   asynchronous active-low reset
//  clr            in   1   synchronous clear: pointers, FSM and counters to reset values
//  wr_en          in   1   one-cycle write strobe from the readout sequencer (FIFO_WE)
//  wr_data        in   16  word qualified by wr_en
//  rd_valid       out  1   rd_data/rd_last hold a committed word
//  rd_ready       in   1   consumer accepts the word when rd_valid & rd_ready
//  rd_data        out  16  output word
//  rd_last        out  1   rd_data is the STATUS word (end of packet)
//  pkt_count      out  8   committed packets not yet fully read (saturates at 255)
//  drop_cnt       out  16  packets discarded (overflow/abort); wraps
//  perr_cnt       out  16  info/data words with bad parity; wraps
//  junk_cnt       out  16  words received outside a packet; wraps
// BEHAVIOUR
//  Reset/clr: all outputs, counters and pointers are 0; FSM is HUNT.
//  Storage and pointers
//  - 17-bit storage: {last, data}.
//  - Pointers: wptr (speculative write), cptr (commit), rptr (read).
//  Framer FSM (advances only on wr_en)
//  - HUNT: 0xAAAA -> store, go TINFO. Any other word -> discard, junk_cnt++.
//  - TINFO: store, go CINFO.
//  - CINFO:
//    - 0xBBBB -> store, go STAT.
//    - 0xAAAA -> abort, restart with this word as a new header (drop_cnt++, stay framing).
//    - Any other word -> store as CH-INFO, go DATA.
//  - DATA: store, go CINFO.
//  - STAT: store with last=1; commit when the packet is clean; go HUNT.
//  - Position resolves ambiguity: 0xBBBB is a legal DATA word; the trailer is recognised only in CINFO.
//  Parity
//  - Info words (TINFO/CINFO): require bit15 == ^bits[14:8].
//  - DATA words: require bit15 == ^bits[14:0].
//  - Mismatch: perr_cnt++. The packet is still committed.
//  Overflow
//  - A store with (wptr+1)==rptr, or word count == MAX_WORDS, sets ovf.
//  - Further stores in that packet are suppressed.
//  - At STAT (or on abort): wptr <= cptr, drop_cnt++, no commit.
//  Commit
//  - Clock edge N samples the STAT word. At edge N: cptr <= wptr+1 and pkt_count++.
//  - rd_valid is high from edge N+1 with the packet's first word (1-cycle registered output).
//  Read side
//  - Output register loads mem[rptr] when (!rd_valid | rd_ready) and rptr != cptr.
//  - Full throughput: 1 word/cycle.
//  - Pop of a word with rd_last=1: pkt_count--.
//  - Commit and last-word pop in the same cycle: pkt_count unchanged.
//  - rd_data/rd_last stay stable while rd_valid & !rd_ready.
//  - Uncommitted words are never visible on the read side.
//  Pointers: ADDR_W bits, natural wrap-around. Write and read in the same cycle are always legal.
//  Reset mid-packet: all partial and committed data is discarded; the first accepted word after reset is a header.
// STRUCTURE
//  - rdo_pkg: HEADER_W=16'hAAAA, TRAILER_W=16'hBBBB, framer state enum (HUNT,TINFO,CINFO,DATA,STAT),
//    parity helper functions.
//  - One sub-module: rdo_sdp_ram.
//    - Simple dual-port, 2**ADDR_W x 17, synchronous write, registered read.
//    - Infers block RAM.
//  - Framer, pointers, counters and the output stage stay in this module.
// TESTING
//  1 Clean packet:
//    - Stimulus: AAAA,0300,0500,0123,BBBB,0000 at one strobe per 4 cycles; rd_ready=1.
//    - Expect: the same 6 words out; rd_last on word 6; pkt_count 0->1->0; all counters 0.
//  2 Overflow:
//    - Stimulus: ADDR_W=4, rd_ready=0, 20-word packet.
//    - Expect: drop_cnt=1, pkt_count=0, rd_valid stays 0.
//    - Then a 6-word packet is delivered intact.
//  3 Header mid-packet:
//    - Stimulus: AAAA,0300,0500,0123,AAAA,0380,BBBB,0000.
//    - Expect: drop_cnt=1; one packet AAAA,0380,BBBB,0000 out.
//  4 Parity error:
//    - Stimulus: test 1 with data word 8123.
//    - Expect: perr_cnt=1; packet delivered with 8123 unchanged.
//  5 Junk and ambiguity:
//    - Stimulus: 1234,BBBB before a packet whose data word is BBBB.
//    - Expect: junk_cnt=2; packet of 6 words out with BBBB as word 4.
//  6 Back-pressure and reset:
//    - Stimulus: toggle rd_ready randomly over 3 queued packets.
//    - Expect: order preserved and the last-pop/commit same-cycle case counted correctly.
//    - Then assert rstn low mid-packet: all outputs 0; the next clean packet is delivered.

Source files
------------

// File: rtl/rdo_pkg.sv
// rtl/rdo_pkg.sv - frame markers, framer states and parity rules for the readout buffer
package rdo_pkg;

  localparam logic [15:0] HEADER_W  = 16'hAAAA;
  localparam logic [15:0] TRAILER_W = 16'hBBBB;

  typedef enum logic [2:0] {
    HUNT,
    TINFO,
    CINFO,
    DATA,
    STAT
  } frm_state_t;

  // Info words carry odd/even parity of their upper byte only; data words cover all 15 bits.
  function automatic logic info_par_ok(input logic [15:0] w);
    return w[15] == ^w[14:8];
  endfunction

  function automatic logic data_par_ok(input logic [15:0] w);
    return w[15] == ^w[14:0];
  endfunction

endpackage

// File: rtl/rdo_sdp_ram.sv
// rtl/rdo_sdp_ram.sv - simple dual-port word store, synchronous write, registered read
module rdo_sdp_ram #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 17
) (
  input  logic              clk_sys,
  input  logic              i_rstn,
  input  logic              i_clr,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_q
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_q;

  always_ff @(posedge clk_sys) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // The read register doubles as the stream output register, so it holds while not re-enabled.
  always_ff @(posedge clk_sys or negedge i_rstn) begin
    if (!i_rstn)    r_q <= '0;
    else if (i_clr) r_q <= '0;
    else if (i_re)  r_q <= r_mem[i_raddr];
  end

  assign o_q = r_q;

endmodule

// File: rtl/rdo_packet_buffer.sv
// rtl/rdo_packet_buffer.sv - framing readout buffer that stores speculatively and streams only committed packets
module rdo_packet_buffer
  import rdo_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int MAX_WORDS = 200
) (
  input  logic        clk_sys,
  input  logic        rstn,
  input  logic        clr,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [15:0] rd_data,
  output logic        rd_last,
  output logic [7:0]  pkt_count,
  output logic [15:0] drop_cnt,
  output logic [15:0] perr_cnt,
  output logic [15:0] junk_cnt
);

  localparam int CNT_W = $clog2(MAX_WORDS + 1);

  frm_state_t        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_wptr, r_cptr, r_rptr, w_base, w_base_inc;
  logic [CNT_W-1:0]  r_wcnt, w_cnt_base;
  logic              r_ovf, w_ovf_base, w_ovf_now, r_valid;
  logic [7:0]        r_pkt_cnt;
  logic [15:0]       r_drop, r_perr, r_junk;
  logic              w_hdr, w_trl, w_start, w_abort, w_store, w_stat;
  logic              w_we, w_commit, w_drop, w_junk, w_perr;
  logic              w_avail, w_rd_take, w_load, w_pop_last;
  logic [16:0]       w_q;

  always_comb begin
    w_state_nxt = r_state;
    if (wr_en) begin
      case (r_state)
        HUNT:    if (w_hdr) w_state_nxt = TINFO;
        TINFO:   w_state_nxt = CINFO;
        CINFO:   if (w_hdr)      w_state_nxt = TINFO;
                 else if (w_trl) w_state_nxt = STAT;
                 else            w_state_nxt = DATA;
        DATA:    w_state_nxt = CINFO;
        STAT:    w_state_nxt = HUNT;
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  assign w_hdr   = (wr_data == HEADER_W);
  assign w_trl   = (wr_data == TRAILER_W);
  assign w_abort = wr_en && (r_state == CINFO) && w_hdr;
  assign w_start = w_abort || (wr_en && (r_state == HUNT) && w_hdr);
  assign w_store = wr_en && ((r_state != HUNT) || w_hdr);
  assign w_stat  = wr_en && (r_state == STAT);
  assign w_junk  = wr_en && (r_state == HUNT) && !w_hdr;
  assign w_perr  = wr_en && (((r_state == TINFO) && !info_par_ok(wr_data)) ||
                             ((r_state == CINFO) && !w_hdr && !w_trl && !info_par_ok(wr_data)) ||
                             ((r_state == DATA) && !data_par_ok(wr_data)));

  // A header (fresh or restarting an aborted packet) always begins at the commit pointer.
  assign w_base     = w_start ? r_cptr : r_wptr;
  assign w_base_inc = w_base + ADDR_W'(1);
  assign w_cnt_base = w_start ? '0 : r_wcnt;
  assign w_ovf_base = w_start ? 1'b0 : r_ovf;
  assign w_ovf_now  = w_ovf_base || (w_base_inc == r_rptr) || (w_cnt_base == CNT_W'(MAX_WORDS));
  assign w_we       = w_store && !w_ovf_now;
  assign w_commit   = w_stat && !w_ovf_now;
  assign w_drop     = w_abort || (w_stat && w_ovf_now);

  assign w_avail    = (r_rptr != r_cptr);
  assign w_rd_take  = !r_valid || rd_ready;
  assign w_load     = w_rd_take && w_avail;
  assign w_pop_last = r_valid && rd_ready && w_q[16];

  rdo_sdp_ram #(.ADDR_W(ADDR_W), .DATA_W(17)) u_ram (
    .clk_sys (clk_sys),
    .i_rstn  (rstn),
    .i_clr   (clr),
    .i_we    (w_we),
    .i_waddr (w_base),
    .i_wdata ({w_stat, wr_data}),
    .i_re    (w_load),
    .i_raddr (r_rptr),
    .o_q     (w_q)
  );

  always_ff @(posedge clk_sys or negedge rstn) begin
    if (!rstn) begin
      r_state <= HUNT;
      r_wptr  <= '0;
      r_cptr  <= '0;
      r_wcnt  <= '0;
      r_ovf   <= 1'b0;
    end else if (clr) begin
      r_state <= HUNT;
      r_wptr  <= '0;
      r_cptr  <= '0;
      r_wcnt  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_commit) begin
        r_wptr <= w_base_inc;
        r_cptr <= w_base_inc;
      end else if (w_stat) begin
        r_wptr <= r_cptr;
      end else if (w_store) begin
        r_wptr <= w_we ? w_base_inc : w_base;
        r_wcnt <= w_we ? w_cnt_base + CNT_W'(1) : w_cnt_base;
        r_ovf  <= w_ovf_now;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge rstn) begin
    if (!rstn) begin
      r_rptr    <= '0;
      r_valid   <= 1'b0;
      r_pkt_cnt <= '0;
      r_drop    <= '0;
      r_perr    <= '0;
      r_junk    <= '0;
    end else if (clr) begin
      r_rptr    <= '0;
      r_valid   <= 1'b0;
      r_pkt_cnt <= '0;
      r_drop    <= '0;
      r_perr    <= '0;
      r_junk    <= '0;
    end else begin
      if (w_rd_take) r_valid <= w_avail;
      if (w_load)    r_rptr  <= r_rptr + ADDR_W'(1);
      case ({w_commit, w_pop_last})
        2'b10:   if (r_pkt_cnt != 8'hFF) r_pkt_cnt <= r_pkt_cnt + 8'd1;
        2'b01:   if (r_pkt_cnt != 8'h00) r_pkt_cnt <= r_pkt_cnt - 8'd1;
        default: r_pkt_cnt <= r_pkt_cnt;
      endcase
      if (w_drop) r_drop <= r_drop + 16'd1;
      if (w_perr) r_perr <= r_perr + 16'd1;
      if (w_junk) r_junk <= r_junk + 16'd1;
    end
  end

  assign rd_valid  = r_valid;
  assign rd_data   = w_q[15:0];
  assign rd_last   = w_q[16];
  assign pkt_count = r_pkt_cnt;
  assign drop_cnt  = r_drop;
  assign perr_cnt  = r_perr;
  assign junk_cnt  = r_junk;

endmodule

// File: tb/tb_rdo_packet_buffer.sv
// tb/tb_rdo_packet_buffer.sv - scoreboard bench for rdo_packet_buffer with a packet-level reference
module tb_rdo_packet_buffer;

  typedef logic [15:0] word_q_t[$];

  logic        clk_sys  = 1'b0;
  logic        rstn     = 1'b0;
  logic        clr      = 1'b0;
  logic        wr_en    = 1'b0;
  logic [15:0] wr_data  = 16'h0;
  logic        rd_ready = 1'b0;
  logic        rd_valid, rd_last;
  logic [15:0] rd_data, drop_cnt, perr_cnt, junk_cnt;
  logic [7:0]  pkt_count;

  int          checks   = 0;
  int          failures = 0;
  logic [16:0] exp_q[$];
  int          m_cnt    = 0;
  logic        tb_commit = 1'b0;
  logic        lat_arm  = 1'b0;
  bit          bp_en    = 1'b0;
  int          exp_drop = 0;
  int          exp_perr = 0;
  int          exp_junk = 0;

  logic        stall_prev = 1'b0;
  logic [16:0] held = '0;
  logic [16:0] e_word;
  int          lat = 0;

  always #10 clk_sys = ~clk_sys;

  rdo_packet_buffer #(.ADDR_W(4), .MAX_WORDS(200)) dut (
    .clk_sys   (clk_sys),
    .rstn      (rstn),
    .clr       (clr),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .pkt_count (pkt_count),
    .drop_cnt  (drop_cnt),
    .perr_cnt  (perr_cnt),
    .junk_cnt  (junk_cnt)
  );

  function automatic bit info_bad(input logic [15:0] w);
    return w[15] != ^w[14:8];
  endfunction

  function automatic bit data_bad(input logic [15:0] w);
    return w[15] != ^w[14:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
    if (bp_en) rd_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Drives one strobe per word; the word at commit_idx is the STATUS word expected to commit expw.
  task automatic send(input word_q_t w, input int commit_idx, input word_q_t expw, input int gap);
    foreach (w[i]) begin
      wr_en   = 1'b1;
      wr_data = w[i];
      if (i == commit_idx) begin
        lat_arm = (exp_q.size() == 0) && !rd_valid;
        foreach (expw[j]) exp_q.push_back({(j == expw.size() - 1), expw[j]});
        tb_commit = 1'b1;
      end
      tick();
      wr_en     = 1'b0;
      tb_commit = 1'b0;
      repeat (gap - 1) tick();
    end
  endtask

  task automatic drain();
    int n = 0;
    bp_en    = 1'b0;
    rd_ready = 1'b1;
    while ((exp_q.size() != 0 || rd_valid) && n < 400) begin
      tick();
      n++;
    end
    chk("drain_done", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic chk_cnts(input string tag);
    chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'(exp_drop));
    chk({tag, "_perr_cnt"}, 32'(perr_cnt), 32'(exp_perr));
    chk({tag, "_junk_cnt"}, 32'(junk_cnt), 32'(exp_junk));
  endtask

  task automatic gen_pkt(output word_q_t p);
    logic [15:0] w;
    int          n;
    p.delete();
    p.push_back(16'hAAAA);
    w = 16'($urandom);
    if (info_bad(w)) exp_perr++;
    p.push_back(w);
    n = $urandom_range(1, 3);
    for (int i = 0; i < n; i++) begin
      do w = 16'($urandom); while (w == 16'hAAAA || w == 16'hBBBB);
      if (info_bad(w)) exp_perr++;
      p.push_back(w);
      w = 16'($urandom);
      if (data_bad(w)) exp_perr++;
      p.push_back(w);
    end
    p.push_back(16'hBBBB);
    p.push_back(16'($urandom));
  endtask

  initial begin
    bit c_now, p_now;
    forever begin
      @(negedge clk_sys);
      if (!rstn) begin
        exp_q.delete();
        m_cnt      = 0;
        stall_prev = 1'b0;
        lat        = 0;
        continue;
      end
      chk("pkt_count", 32'(pkt_count), 32'(m_cnt));
      if (stall_prev) begin
        chk("stall_valid", 32'(rd_valid), 32'(1));
        chk("stall_word", 32'({rd_last, rd_data}), 32'(held));
      end
      if (lat == 1) begin
        chk("commit_latency_edge_n", 32'(rd_valid), 32'(0));
        lat = 2;
      end else if (lat == 2) begin
        chk("commit_latency_edge_n1", 32'(rd_valid), 32'(1));
        lat = 0;
      end
      p_now = 1'b0;
      if (rd_valid && exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL uncommitted_word: got %h last=%0b with no committed word expected", rd_data, rd_last);
      end else if (rd_valid && rd_ready) begin
        e_word = exp_q.pop_front();
        chk("rd_word", 32'({rd_last, rd_data}), 32'(e_word));
        p_now = e_word[16];
      end
      stall_prev = rd_valid && !rd_ready;
      held       = {rd_last, rd_data};
      c_now      = wr_en && tb_commit;
      if (c_now && lat_arm) lat = 1;
      if (c_now && !p_now && m_cnt < 255) m_cnt++;
      else if (p_now && !c_now && m_cnt > 0) m_cnt--;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    word_q_t p, p2, e, none, st;

    repeat (3) tick();
    chk("reset_rd_valid", 32'(rd_valid), 32'(0));
    chk("reset_rd_data", 32'(rd_data), 32'(0));
    chk("reset_rd_last", 32'(rd_last), 32'(0));
    chk("reset_pkt_count", 32'(pkt_count), 32'(0));
    chk_cnts("reset");
    rstn = 1'b1;
    tick();

    rd_ready = 1'b1;
    p = '{16'hAAAA, 16'h0300, 16'h0500, 16'h0123, 16'hBBBB, 16'h0000};
    send(p, 5, p, 4);
    drain();
    chk_cnts("clean");

    rd_ready = 1'b0;
    p.delete();
    p.push_back(16'hAAAA);
    p.push_back(16'h0300);
    for (int i = 0; i < 8; i++) begin
      p.push_back(16'h0500);
      p.push_back(16'h0123);
    end
    p.push_back(16'hBBBB);
    p.push_back(16'h0000);
    send(p, -1, none, 2);
    exp_drop++;
    repeat (3) tick();
    chk("ovf_rd_valid", 32'(rd_valid), 32'(0));
    chk("ovf_pkt_count", 32'(pkt_count), 32'(0));
    chk_cnts("ovf");
    rd_ready = 1'b1;
    p = '{16'hAAAA, 16'h0300, 16'h0500, 16'h0123, 16'hBBBB, 16'h0000};
    send(p, 5, p, 1);
    drain();

    p = '{16'hAAAA, 16'h0300, 16'h0500, 16'h0123, 16'hAAAA, 16'h0380, 16'hBBBB, 16'h0000};
    e = '{16'hAAAA, 16'h0380, 16'hBBBB, 16'h0000};
    send(p, 7, e, 2);
    exp_drop++;
    drain();
    chk_cnts("hdr_mid");

    p = '{16'hAAAA, 16'h0300, 16'h0500, 16'h8123, 16'hBBBB, 16'h0000};
    send(p, 5, p, 3);
    exp_perr++;
    drain();
    chk_cnts("parity");

    p = '{16'h1234, 16'hBBBB};
    send(p, -1, none, 2);
    exp_junk += 2;
    p = '{16'hAAAA, 16'h0300, 16'h0500, 16'hBBBB, 16'hBBBB, 16'h0000};
    send(p, 5, p, 2);
    drain();
    chk_cnts("junk");

    clr = 1'b1;
    tick();
    clr = 1'b0;
    exp_drop = 0;
    exp_perr = 0;
    exp_junk = 0;
    chk_cnts("clr");

    rd_ready = 1'b0;
    p  = '{16'hAAAA, 16'h0300, 16'h0500, 16'h0123, 16'hBBBB, 16'h0001};
    send(p, 5, p, 2);
    p2 = '{16'hAAAA, 16'h0300, 16'h0500, 16'h0123, 16'hBBBB, 16'h0002};
    e  = '{16'hAAAA, 16'h0300, 16'h0500, 16'h0123, 16'hBBBB};
    send(e, -1, none, 2);
    rd_ready = 1'b1;
    repeat (5) tick();
    st = '{16'h0002};
    send(st, 0, p2, 1);
    chk("same_cycle_pkt_count", 32'(pkt_count), 32'(1));
    drain();

    bp_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      gen_pkt(p);
      send(p, p.size() - 1, p, 2);
    end
    drain();
    chk_cnts("backpressure");

    rd_ready = 1'b0;
    p = '{16'hAAAA, 16'h0300, 16'h0500, 16'h0123, 16'hBBBB, 16'h0003};
    send(p, 5, p, 2);
    e = '{16'hAAAA, 16'h0300, 16'h0500};
    send(e, -1, none, 2);
    chk("pre_reset_rd_valid", 32'(rd_valid), 32'(1));
    #3 rstn = 1'b0;
    #1;
    chk("rst_rd_valid", 32'(rd_valid), 32'(0));
    chk("rst_rd_data", 32'(rd_data), 32'(0));
    chk("rst_rd_last", 32'(rd_last), 32'(0));
    chk("rst_pkt_count", 32'(pkt_count), 32'(0));
    exp_drop = 0;
    exp_perr = 0;
    exp_junk = 0;
    chk_cnts("rst");
    tick();
    tick();
    rstn     = 1'b1;
    rd_ready = 1'b1;
    p = '{16'hAAAA, 16'h0380, 16'h0500, 16'h0123, 16'hBBBB, 16'h0004};
    send(p, 5, p, 2);
    drain();
    chk_cnts("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
